// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet control path.
package maxnet_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MULT  = 3'd2,
        S_ADD   = 3'd3,
        S_ACT   = 3'd4,
        S_WRITE = 3'd5,
        S_CHECK = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [3:0] SEL_EXT    = 4'b1111;
    localparam logic [3:0] SEL_FB     = 4'b0000;
    localparam int         ITER_W_DEF = 6;

endpackage

// File: rtl/maxnet_iter_cnt.sv
// Iteration counter: clears on run start, increments per write-back, saturates at MAX_ITER.
module maxnet_iter_cnt
    import maxnet_pkg::*;
#(
    parameter int ITER_W   = ITER_W_DEF,
    parameter int MAX_ITER = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ITER_W-1:0] count,
    output logic              at_limit
);

    assign at_limit = (count == ITER_W'(MAX_ITER));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !at_limit)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/maxnet_sequencer.sv
// Maxnet control FSM: load, then MULT/ADD/ACT/WRITE/CHECK until found, timeout or abort.
module maxnet_sequencer
    import maxnet_pkg::*;
#(
    parameter int MAX_ITER = 63,
    parameter int ITER_W   = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              found,
    output logic              main_reg_write,
    output logic [3:0]        sel,
    output logic              mult_write,
    output logic              add_write,
    output logic              act_write,
    output logic              done,
    output logic              busy,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    state_t state, nxt;
    logic   cnt_clr, cnt_inc, at_limit, do_abort;

    assign do_abort = abort && (state != S_IDLE);
    assign cnt_clr  = (state == S_IDLE) && start;
    assign cnt_inc  = (state == S_WRITE) && !do_abort;

    maxnet_iter_cnt #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .count    (iter_count),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = S_LOAD;
            S_LOAD:  nxt = S_MULT;
            S_MULT:  nxt = S_ADD;
            S_ADD:   nxt = S_ACT;
            S_ACT:   nxt = S_WRITE;
            S_WRITE: nxt = S_CHECK;
            S_CHECK: begin
                if (found)         nxt = S_DONE;
                else if (at_limit) nxt = S_IDLE;
                else               nxt = S_MULT;
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        // Abort outranks every transition, including CHECK->DONE.
        if (do_abort)
            nxt = S_IDLE;
    end

    always_comb begin
        main_reg_write = 1'b0;
        sel            = SEL_FB;
        mult_write     = 1'b0;
        add_write      = 1'b0;
        act_write      = 1'b0;
        done           = 1'b0;
        busy           = (state != S_IDLE);
        case (state)
            S_LOAD:  begin main_reg_write = 1'b1; sel = SEL_EXT; end
            S_MULT:  mult_write = 1'b1;
            S_ADD:   add_write  = 1'b1;
            S_ACT:   act_write  = 1'b1;
            S_WRITE: main_reg_write = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout <= 1'b0;
        else if (cnt_clr)
            timeout <= 1'b0;
        else if (state == S_CHECK && !do_abort && !found && at_limit)
            timeout <= 1'b1;
    end

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Scoreboard bench for maxnet_sequencer with a counting datapath model for found.
module tb_maxnet_sequencer;

    localparam int ITER_W   = 6;
    localparam int MAX_ITER = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              found;
    logic              main_reg_write, mult_write, add_write, act_write, done, busy, timeout;
    logic [3:0]        sel;
    logic [ITER_W-1:0] iter_count;

    maxnet_sequencer #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .found          (found),
        .main_reg_write (main_reg_write),
        .sel            (sel),
        .mult_write     (mult_write),
        .add_write      (add_write),
        .act_write      (act_write),
        .done           (done),
        .busy           (busy),
        .timeout        (timeout),
        .iter_count     (iter_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // found rises after conv_n feedback writes; 0 = always found, -1 = never
    int conv_n = -1;
    int wcnt = 0;
    assign found = (conv_n == 0) || (conv_n > 0 && wcnt >= conv_n);
    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (main_reg_write && sel == 4'hF) wcnt <= 0;
        else if (main_reg_write && sel == 4'h0) wcnt <= wcnt + 1;
    end

    typedef struct {
        bit exp_done;
        int done_cyc;
        int idle_cyc;
        int iter;
        bit tmo;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: cycle-accurate strobe model plus end-of-run scoreboard compare.
    int  cyc = 0, start_cyc = 0, serr = 0, dcyc = -1;
    bit  pbusy = 0, dseen = 0;
    always @(negedge clk) begin
        int r;
        logic [8:0] act_v, exp_v;
        exp_t e;
        cyc++;
        if (busy && !pbusy) begin
            start_cyc = cyc; serr = 0; dseen = 0; dcyc = -1;
            chk("load_timeout_clr", int'(timeout), 0);
            chk("load_iter_clr", int'(iter_count), 0);
        end
        if (busy) begin
            r = cyc - start_cyc + 1;
            act_v = {main_reg_write, sel, mult_write, add_write, act_write, done};
            if (done) begin dseen = 1; dcyc = r; end
            if (sb.size() > 0 && sb[0].exp_done && r == sb[0].done_cyc) exp_v = 9'b0_0000_0001;
            else if (r == 1)                                            exp_v = 9'b1_1111_0000;
            else case ((r - 2) % 5)
                0:       exp_v = 9'b0_0000_1000;
                1:       exp_v = 9'b0_0000_0100;
                2:       exp_v = 9'b0_0000_0010;
                3:       exp_v = 9'b1_0000_0000;
                default: exp_v = 9'b0_0000_0000;
            endcase
            if (act_v != exp_v) serr++;
        end
        if (!busy && pbusy) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("idle_cycle", cyc - start_cyc + 1, e.idle_cyc);
                chk("done_seen", int'(dseen), int'(e.exp_done));
                chk("done_cycle", dcyc, e.exp_done ? e.done_cyc : -1);
                chk("iter_count", int'(iter_count), e.iter);
                chk("timeout", int'(timeout), int'(e.tmo));
                chk("strobe_errs", serr, 0);
            end
        end
        pbusy = busy;
    end

    task automatic expect_run(input bit d, input int dc, input int ic, input int it, input bit t);
        exp_t e;
        e.exp_done = d; e.done_cyc = dc; e.idle_cyc = ic; e.iter = it; e.tmo = t;
        sb.push_back(e);
    endtask

    // Called at posedge+1 of an idle cycle; that cycle becomes cycle 0.
    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("wait_idle_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic conv_run(input int n);
        conv_n = n;
        expect_run(1, 5 * (n == 0 ? 1 : n) + 2, 5 * (n == 0 ? 1 : n) + 3, (n == 0 ? 1 : n), 0);
        start_run();
        wait_idle();
    endtask

    initial begin
        #1;
        chk("reset_outputs", int'({main_reg_write, sel, mult_write, add_write, act_write, done, busy, timeout, iter_count}), 0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);

        conv_run(3);                              // done cycle 17, iter 3

        conv_n = -1;                              // timeout: IDLE in cycle 22
        expect_run(0, 0, 22, 4, 1);
        start_run();
        wait_idle();

        conv_run(3);                              // start clears timeout

        conv_n = 2;                               // abort in CHECK of iteration 2 (cycle 11)
        expect_run(0, 0, 12, 2, 0);
        start_run();
        wait_cyc(10);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle();

        conv_run(0);                              // found from reset: done in cycle 7

        conv_n = 3;                               // start pulsed while busy is ignored
        expect_run(1, 17, 18, 3, 0);
        start_run();
        wait_cyc(4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        conv_n = 1;                               // start with abort in IDLE starts a run
        expect_run(1, 7, 8, 1, 0);
        abort = 1'b1;
        start_run();
        abort = 1'b0;
        wait_idle();

        conv_n = 3;                               // reset asserted mid-ADD (cycle 3)
        expect_run(0, 0, 3, 0, 0);
        start_run();
        wait_cyc(2);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({main_reg_write, sel, mult_write, add_write, act_write, done, busy, timeout, iter_count}), 0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(1);

        conv_run(2);                              // normal run after reset

        wait_cyc(3);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/maxnet_sequencer.md
# maxnet_sequencer

Control FSM that drives the Maxnet datapath through its iteration loop: loads the four inputs, then runs multiply / add / activate / write-back phases until the datapath reports a single survivor (`found`) or an iteration limit expires. It sits beside the datapath in the Maxnet top and adds an abort input, a bounded iteration count, a busy flag and a timeout flag.

## Interface
- `MAX_ITER`, default 63: maximum completed iterations before timeout; range 1..2^ITER_W-1.
- `ITER_W`, default 6: width of the iteration counter.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of the current run.
- `found`  in  1  datapath flag: exactly one main register nonzero.
- `main_reg_write`  out  1  main registers capture the mux output.
- `sel`  out  4  per-lane mux select; 1 selects the external input, 0 selects the activation feedback.
- `mult_write`  out  1  epsilon-product register write enable.
- `add_write`  out  1  adder register write enable.
- `act_write`  out  1  activation register write enable.
- `done`  out  1  one-cycle pulse on successful convergence.
- `busy`  out  1  high in every state except IDLE.
- `timeout`  out  1  sticky; set on iteration-limit failure.
- `iter_count`  out  ITER_W  completed iterations of the current or last run.

## Operation
- States: IDLE, LOAD, MULT, ADD, ACT, WRITE, CHECK, DONE.
- IDLE:
  - all strobes are 0 and `sel` is 0;
  - `start` = 1 moves to LOAD, clears `timeout` and clears `iter_count`.
- LOAD: `main_reg_write` = 1 and `sel` = 4'b1111. Always moves to MULT.
  - At least one iteration always runs, even when the inputs already satisfy `found`.
- MULT, ADD and ACT each assert only their own strobe (`mult_write`, `add_write`, `act_write`) for one cycle, then advance in order.
- WRITE: `main_reg_write` = 1 with `sel` = 4'b0000, and `iter_count` increments. Moves to CHECK.
- CHECK samples `found`, with priority in this order:
  1. `found` = 1 goes to DONE.
  2. Otherwise, `iter_count` == MAX_ITER goes to IDLE and sets `timeout`; `done` stays 0.
  3. Otherwise the FSM loops to MULT.
- DONE: `done` = 1 for one cycle, then IDLE.
- `abort` = 1 in any state other than IDLE forces IDLE at the next edge.
  - No `done`, `timeout` is unchanged, and `iter_count` holds its value.
  - `abort` takes precedence over every other transition, including CHECK→DONE.
- `start` is ignored while `busy`. `start` and `abort` together in IDLE: `start` wins, because `abort` has no effect in IDLE.
- `iter_count` saturates at MAX_ITER; it cannot wrap, because CHECK exits at that value.
- All outputs are Moore, decoded from state registers only. `timeout` and `iter_count` are registers.

## Timing
- Reset values: state IDLE; every output 0, including `timeout` and `iter_count`.
- Cycle numbering: the edge that samples `start` ends cycle 0.
- LOAD occupies cycle 1.
- Iteration k (k ≥ 1) occupies cycles 5k−3 .. 5k+1, as MULT, ADD, ACT, WRITE, CHECK.
- Convergence after N iterations: `done` is high in cycle 5N+2. `busy` drops in cycle 5N+3.
- Timeout: IDLE is entered in cycle 5·MAX_ITER+2, with `timeout` high from that cycle.
- `found` must be valid in CHECK, one cycle after the WRITE edge. The datapath's `found` logic is combinational on the main registers.
- Back-to-back runs: `start` high in the cycle `busy` first reads 0 is accepted.

## Structure
- `maxnet_pkg` holds:
  - the state enum (8 states, 3-bit encoding);
  - the `SEL_EXT` = 4'b1111 and `SEL_FB` = 4'b0000 constants;
  - the default ITER_W.
- One sub-module, `maxnet_iter_cnt`: a counter with clear, increment and saturating compare to MAX_ITER, producing `at_limit`. The FSM and output decode remain in `maxnet_sequencer`.

## Test plan
- Reset asserted mid-ADD → all outputs 0 immediately (asynchronous) and state IDLE. A `start` after reset release behaves normally.
- `start` with a datapath model converging after 3 iterations → strobe order LOAD, then (MULT, ADD, ACT, WRITE, CHECK)×3. `done` pulses in cycle 17, `iter_count` = 3, `timeout` = 0.
- MAX_ITER = 4 with `found` held 0 → return to IDLE in cycle 22, `timeout` = 1, `iter_count` = 4, no `done`. The next `start` clears `timeout`.
- `abort` in CHECK while `found` = 1 (iteration 2) → IDLE next cycle, no `done`, `iter_count` = 2.
- `found` = 1 from reset (inputs already have a single nonzero) → exactly one iteration runs, `done` in cycle 7.
- `start` pulsed while `busy`, plus `start` and `abort` together in IDLE → the first is ignored and the run timing is unchanged; the second starts a run.
